// File: rtl/interval_timer.sv
// Interval timer: counts `value` seconds of DIVIDER clk cycles each; start is always accepted (no backpressure).
// Latency: expired pulses value*DIVIDER cycles after the start edge, or one edge after start when value is 0.
module interval_timer #(
  parameter int DIVIDER = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] value,
  input  logic       start_timer,
  output logic       expired,
  output logic       busy,
  output logic [3:0] remaining
);

  localparam int PW = $clog2(DIVIDER);
  localparam logic [PW-1:0] PRESCALE_LAST = PW'(DIVIDER - 1);

  typedef enum logic [0:0] {IDLE, COUNT} state_t;

  state_t        state;
  logic [PW-1:0] prescaler;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      prescaler <= '0;
      remaining <= '0;
      busy      <= 1'b0;
      expired   <= 1'b0;
    end else begin
      expired <= 1'b0;
      if (start_timer) begin
        // A start always wins over a tick landing on the same edge.
        prescaler <= '0;
        if (value != 4'd0) begin
          remaining <= value;
          state     <= COUNT;
          busy      <= 1'b1;
        end else begin
          remaining <= 4'd0;
          state     <= IDLE;
          busy      <= 1'b0;
          expired   <= 1'b1;
        end
      end else if (state == COUNT) begin
        if (prescaler == PRESCALE_LAST) begin
          prescaler <= '0;
          if (remaining <= 4'd1) begin
            remaining <= 4'd0;
            state     <= IDLE;
            busy      <= 1'b0;
            expired   <= 1'b1;
          end else begin
            remaining <= remaining - 4'd1;
          end
        end else begin
          prescaler <= prescaler + PW'(1);
        end
      end
    end
  end

endmodule
